// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, data port and single-port memory signals shared by
// mem_arbiter (slave view) and its environment (master view).
interface mem_arb_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_wdata, mem_wren
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_wdata, mem_wren
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch + data) in front of a single-port synchronous memory.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed data priority.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_arb_if.slave   bus
);
    typedef enum logic {PRI_D = 1'b0, PRI_IF = 1'b1} pri_e;

    pri_e              state_q;
    pri_e              state_d;
    logic              active_q;
    logic              if_gnt_p0;
    logic              d_gnt_p0;
    logic              rd_gnt_p0;
    logic              pending_p1;
    logic              owner_if_p1;
    logic [ADDR_W-1:0] addr_q;

    // Grants are held off for the cycle following reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= PRI_D;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    // Stage p0: combinational grant and next priority
    always_comb begin
        state_d   = state_q;
        if_gnt_p0 = 1'b0;
        d_gnt_p0  = 1'b0;
        if (active_q) begin
            case (state_q)
                PRI_D: begin
                    if (bus.d_req)       d_gnt_p0  = 1'b1;
                    else if (bus.if_req) if_gnt_p0 = 1'b1;
                end
                PRI_IF: begin
                    if (bus.if_req)      if_gnt_p0 = 1'b1;
                    else if (bus.d_req)  d_gnt_p0  = 1'b1;
                end
                default: ;
            endcase
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (active_q && bus.if_req && bus.d_req)
            state_d = d_gnt_p0 ? PRI_IF : PRI_D;
`else
        state_d = PRI_D;
`endif
    end

    assign rd_gnt_p0 = if_gnt_p0 | (d_gnt_p0 & ~bus.d_we);

    assign bus.if_gnt    = if_gnt_p0;
    assign bus.d_gnt     = d_gnt_p0;
    assign bus.mem_wren  = d_gnt_p0 & bus.d_we;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.mem_addr  = if_gnt_p0 ? bus.if_addr :
                           d_gnt_p0  ? bus.d_addr  : addr_q;

    always_ff @(posedge clk) begin
        if (!rst)
            addr_q <= '0;
        else if (if_gnt_p0)
            addr_q <= bus.if_addr;
        else if (d_gnt_p0)
            addr_q <= bus.d_addr;
    end

    // Stage p1: response tag, aligned with mem_q
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_p1  <= 1'b0;
            owner_if_p1 <= 1'b0;
        end else begin
            pending_p1  <= rd_gnt_p0;
            owner_if_p1 <= if_gnt_p0;
        end
    end

    assign bus.if_rvalid = pending_p1 & owner_if_p1;
    assign bus.d_rvalid  = pending_p1 & ~owner_if_p1;
    assign bus.if_rdata  = bus.mem_q;
    assign bus.d_rdata   = bus.mem_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed scoreboard bench for mem_arbiter with a write-first memory model.
module tb_mem_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          is_if;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t sbq[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    bit    chk_en   = 1'b0;

    function automatic logic [31:0] init_val(input logic [ADDR_W-1:0] a);
        if (a == 12'h010) return 32'hDEADBEEF;
        return {a, 20'h0} ^ 32'h5A5A_3C3C ^ {20'h0, a};
    endfunction

    // Environment memory: synchronous, write-first
    logic [31:0] mem    [DEPTH];
    bit          mem_wr [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_wren) begin
            mem[bus.mem_addr]    <= bus.mem_wdata;
            mem_wr[bus.mem_addr] <= 1'b1;
        end
        if (bus.mem_wren)
            bus.mem_q <= bus.mem_wdata;
        else
            bus.mem_q <= mem_wr[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: memory contents, priority preference, last address
    logic [31:0]       ref_mem [DEPTH];
    bit                ref_wr  [DEPTH];
    bit                m_active = 1'b0;
    bit                m_fav_if = 1'b0;
    logic [ADDR_W-1:0] m_last   = '0;

    always @(negedge clk) begin
        bit                e_if;
        bit                e_d;
        bit                both;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0]       rd;
        if (chk_en) begin
            e_if = 1'b0;
            e_d  = 1'b0;
            both = m_active && bus.if_req && bus.d_req;
            if (m_active) begin
                if (both) begin
                    if (m_fav_if) e_if = 1'b1; else e_d = 1'b1;
                end else if (bus.d_req) e_d = 1'b1;
                else if (bus.if_req)    e_if = 1'b1;
            end
            check("if_gnt",   32'(bus.if_gnt),   32'(e_if));
            check("d_gnt",    32'(bus.d_gnt),    32'(e_d));
            check("mem_wren", 32'(bus.mem_wren), 32'(e_d && bus.d_we));
            e_addr = e_if ? bus.if_addr : (e_d ? bus.d_addr : m_last);
            check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            if (e_d && bus.d_we)
                check("mem_wdata", bus.mem_wdata, bus.d_wdata);
            if (rst && (e_if || (e_d && !bus.d_we))) begin
                rd = ref_wr[e_addr] ? ref_mem[e_addr] : init_val(e_addr);
                sbq.push_back('{e_if, rd, cyc + 1});
            end
            if (e_d && bus.d_we) begin
                ref_mem[bus.d_addr] = bus.d_wdata;
                ref_wr[bus.d_addr]  = 1'b1;
            end
            if (e_if || e_d) m_last = e_addr;
`ifdef ARB_ROUND_ROBIN_EN
            if (both) m_fav_if = e_d;
`endif
            if (!rst) begin
                m_last   = '0;
                m_fav_if = 1'b0;
            end
            m_active = rst;
        end
    end

    // Monitor: responses due this cycle must appear on the right port
    always @(negedge clk) begin
        resp_t r;
        bit    x_if;
        bit    x_d;
        if (chk_en) begin
            x_if = 1'b0;
            x_d  = 1'b0;
            r    = '{1'b0, 32'h0, 0};
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                r    = sbq.pop_front();
                x_if = r.is_if;
                x_d  = !r.is_if;
            end
            check("if_rvalid", 32'(bus.if_rvalid), 32'(x_if));
            check("d_rvalid",  32'(bus.d_rvalid),  32'(x_d));
            if (x_if) check("if_rdata", bus.if_rdata, r.data);
            if (x_d)  check("d_rdata",  bus.d_rdata,  r.data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit gi;
        bit gd;
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h010;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 12'h100;
        bus.d_wdata = 32'h0;
        rst         = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        step();
        rst = 1'b1;
        // Contention: one blocked cycle after reset, then four contested grants
        for (int k = 0; k < 5; k++) begin
            step();
            bus.d_addr = 12'h101 + 12'(k);
        end
        bus.d_req = 1'b0;
        step();
        bus.if_req = 1'b0;
        step();
        // Lone fetch of a preloaded word
        bus.if_req  = 1'b1;
        bus.if_addr = 12'h010;
        step();
        bus.if_req = 1'b0;
        step();
        // Write then read of the same address
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 12'h020;
        bus.d_wdata = 32'h12345678;
        step();
        bus.d_we = 1'b0;
        step();
        bus.d_req = 1'b0;
        step();
        // Read granted in the cycle whose closing edge samples reset
        bus.d_req  = 1'b1;
        bus.d_addr = 12'h030;
        rst        = 1'b0;
        step();
        bus.d_req = 1'b0;
        rst       = 1'b1;
        step();
        step();
        // Random traffic over a small address window to hit read-after-write
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            gi = bus.if_gnt;
            gd = bus.d_gnt;
            step();
            if (!bus.if_req || gi) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = 12'($urandom_range(0, 15));
            end
            if (!bus.d_req || gd) begin
                bus.d_req   = ($urandom_range(0, 3) != 0);
                bus.d_we    = $urandom_range(0, 1) != 0;
                bus.d_addr  = 12'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
            end
            rst = ($urandom_range(0, 49) != 0);
        end
        rst        = 1'b1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (4) step();
        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
